// File: rtl/timer_entry.sv
// timer_entry: keypad front end for the microwave timer digit chain.
// Gathers up to four BCD digits (MM:SS) and checks them on START.
// Loads the down-counter chain and paces it with a divided count enable.
// Also tracks the run, pause and done phases of a cook cycle.
module timer_entry #(
  parameter int TICK_DIV     = 100,
  parameter int SEC_TENS_MAX = 5
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  input  logic       door_closed,
  input  logic       timer_done,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       loadn,
  output logic       count_en,
  output logic [2:0] entry_cnt,
  output logic       done,
  output logic       err,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ENTRY = 3'd1,
    LOAD  = 3'd2,
    RUN   = 3'd3,
    PAUSE = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam int             TW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0]  TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [3:0]     SEC_MAX   = 4'(SEC_TENS_MAX);

  state_t        cur;
  state_t        nxt;
  logic [15:0]   digits;
  logic [15:0]   digits_nxt;
  logic [2:0]    cnt_nxt;
  logic [TW-1:0] tick;
  logic [TW-1:0] tick_nxt;
  logic          ce_nxt;
  logic          err_nxt;

  logic is_digit;
  logic is_start;
  logic is_stop;
  logic is_clear;

  assign is_digit = key_valid && (key_code <= 4'd9);
  assign is_start = key_valid && (key_code == 4'hA);
  assign is_stop  = key_valid && (key_code == 4'hB);
  assign is_clear = key_valid && (key_code == 4'hC);

  // The digit buffer is one shift register; min_tens is the oldest digit.
  assign min_tens = digits[15:12];
  assign min_ones = digits[11:8];
  assign sec_tens = digits[7:4];
  assign sec_ones = digits[3:0];
  assign state    = cur;

  // Next-state, digit buffer, tick divider and one-cycle pulse decisions.
  always_comb begin
    nxt        = cur;
    digits_nxt = digits;
    cnt_nxt    = entry_cnt;
    tick_nxt   = tick;
    ce_nxt     = 1'b0;
    err_nxt    = 1'b0;
    case (cur)
      IDLE, ENTRY: begin
        if (is_clear) begin
          nxt        = IDLE;
          digits_nxt = '0;
          cnt_nxt    = '0;
        end else if (is_digit) begin
          if (entry_cnt < 3'd4) begin
            digits_nxt = {digits[11:0], key_code};
            cnt_nxt    = entry_cnt + 3'd1;
            nxt        = ENTRY;
          end else begin
            err_nxt = 1'b1;
          end
        end else if (is_start) begin
          if (cur == ENTRY && door_closed && digits != '0 && digits[7:4] <= SEC_MAX) begin
            nxt = LOAD;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
      LOAD: begin
        nxt      = RUN;
        tick_nxt = '0;
      end
      RUN: begin
        // Exits freeze the divider so a resume finishes the partial second.
        if (!door_closed) begin
          nxt = PAUSE;
        end else if (timer_done) begin
          nxt = DONE;
        end else if (is_stop || is_clear) begin
          nxt = PAUSE;
        end else if (tick == TICK_LAST) begin
          tick_nxt = '0;
          ce_nxt   = 1'b1;
        end else begin
          tick_nxt = tick + 1'b1;
        end
      end
      PAUSE: begin
        if (is_clear) begin
          nxt        = IDLE;
          digits_nxt = '0;
          cnt_nxt    = '0;
        end else if (is_start) begin
          if (door_closed) begin
            nxt = RUN;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
      DONE: begin
        if (is_clear || !door_closed) begin
          nxt        = IDLE;
          digits_nxt = '0;
          cnt_nxt    = '0;
        end
      end
      default: begin
        nxt        = IDLE;
        digits_nxt = '0;
        cnt_nxt    = '0;
        tick_nxt   = '0;
      end
    endcase
  end

  // State and every output are registered; clr drops the load strobe at once.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      cur       <= IDLE;
      digits    <= '0;
      entry_cnt <= '0;
      tick      <= '0;
      loadn     <= 1'b1;
      count_en  <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      cur       <= nxt;
      digits    <= digits_nxt;
      entry_cnt <= cnt_nxt;
      tick      <= tick_nxt;
      loadn     <= (nxt != LOAD);
      count_en  <= ce_nxt;
      done      <= (nxt == DONE);
      err       <= err_nxt;
    end
  end

endmodule
